boot_loader_ctrl: RTL and testbench
===================================

# boot_loader_ctrl

Boot sequencer between the BIOS ROM, the disk/storage read port and instruction memory. On a start command decoded by the BIOS program, it copies a block of words from storage into instruction memory one word at a time. It then pulses a PC reset and permanently switches instruction fetch from BIOS to instruction memory. It supersedes the bare BIOS/memory fetch switch: the copy runs in hardware, and the switch happens only after the copy completes.

## Interface

Parameters:
- ADDR_W, 10: address width for source (storage) and destination (instruction memory)
- LEN_W, 10: width of the word-count operand

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle copy request; sampled only in IDLE
- srcBase  in  ADDR_W  first storage address; captured with start
- dstBase  in  ADDR_W  first instruction-memory address; captured with start
- length  in  LEN_W  number of words to copy; captured with start
- rdEn  out  1  one-cycle storage read strobe
- rdAddr  out  ADDR_W  storage read address; valid while rdEn is high
- rdData  in  32  storage read data; valid while rdValid is high
- rdValid  in  1  read completion; arrives 1 or more cycles after rdEn
- wrEn  out  1  instruction-memory write strobe, one cycle per word
- wrAddr  out  ADDR_W  instruction-memory write address
- wrData  out  32  instruction-memory write data
- busy  out  1  high in READ, WAIT, WRITE and HANDOFF
- fetchSel  out  1  0 = fetch from BIOS, 1 = fetch from instruction memory
- resetPC  out  1  one-cycle PC reset pulse at handoff; also high while reset is asserted
- err  out  1  checksum failure (only with the macro compiled in; tied 0 without it)

## Operation

- States: IDLE, READ, WAIT, WRITE, HANDOFF, RUN, plus ERROR when the macro is compiled in.
- Reset values: state=IDLE, fetchSel=0, rdEn=0, wrEn=0, busy=0, err=0, internal counters=0. resetPC=1 during each reset cycle and 0 on the first cycle after reset.
- IDLE, start=1, length≠0: capture srcBase, dstBase and length; go to READ.
- IDLE, start=1, length=0: go directly to HANDOFF; no memory traffic.
- READ: assert rdEn for exactly one cycle with rdAddr=src; go to WAIT.
- WAIT: hold until rdValid=1; latch rdData into the data register; go to WRITE. Exactly one read is outstanding at any time.
- WRITE: assert wrEn with wrAddr=dst and wrData=the latched word. Then increment src and dst, and decrement the remaining count. If remaining was 1, go to HANDOFF; otherwise go to READ.
- HANDOFF: assert resetPC for one cycle; set fetchSel=1; go to RUN.
- RUN: terminal state. fetchSel stays 1 and start is ignored until reset.
- Address arithmetic wraps modulo 2^ADDR_W, so 0x3FF+1 → 0x000 when ADDR_W=10.
- length is unsigned; the maximum copy is 2^LEN_W−1 words.
- start outside IDLE is ignored, with no effect on the state or the captured operands.
- rdValid outside WAIT is ignored.
- Reset mid-copy: abort immediately and return to IDLE with fetchSel=0. Memory words already written are left as they are.

## Timing

- Per word: READ takes 1 cycle, WAIT takes at least 1 cycle, WRITE takes 1 cycle. With rdValid arriving the cycle after rdEn, each word takes 3 cycles.
- N-word copy with 1-cycle read latency: start at cycle 0 → first rdEn at cycle 1, last wrEn at cycle 3N, resetPC and fetchSel rising at cycle 3N+1.
- length=0: start at cycle 0 → resetPC at cycle 1.
- fetchSel changes in the same cycle as the resetPC pulse and never returns to 0 without reset.
- All outputs are registered.

## Configuration

- BOOT_CHECKSUM_EN defined:
  - Adds input sumExpected[31:0], captured together with start.
  - Every word written is added into a 32-bit running sum; overflow wraps modulo 2^32.
  - On leaving the last WRITE: if the sum equals sumExpected, go to HANDOFF. Otherwise go to ERROR.
  - ERROR: err=1, fetchSel stays 0, no resetPC pulse, held until reset.
  - length=0 compares a sum of 0 against sumExpected.
- BOOT_CHECKSUM_EN not defined: no sumExpected port, no ERROR state, err tied to 0.

## Structure

- Shared package boot_pkg holds:
  - the state enum and its encoding
  - FETCH_BIOS=1'b0 and FETCH_MEM=1'b1
  - the default ADDR_W and LEN_W
- Single module with no sub-modules. When the macro is compiled in, the checksum accumulator is inline logic in the same module.

## Test plan

- length=4, srcBase=0x010, dstBase=0x000, storage[0x10..0x13]=A,B,C,D, 1-cycle latency → writes 0x000..0x003 = A..D; resetPC pulses at cycle 13; fetchSel=1 from cycle 13 onward.
- length=0 → no rdEn or wrEn; resetPC pulse and fetchSel=1 at cycle 1.
- rdValid delayed 5 cycles per word, length=2 → wrEn only after each rdValid, never more than one outstanding read, correct data written.
- srcBase=0x3FE, dstBase=0x3FF, length=3 → rdAddr sequence 0x3FE, 0x3FF, 0x000; wrAddr sequence 0x3FF, 0x000, 0x001.
- reset asserted during WAIT of the second word, then start again with length=1 → state IDLE, fetchSel=0, resetPC=1 during the reset cycle; the restart copies one word and hands off normally; start pulses in RUN are ignored.
- BOOT_CHECKSUM_EN compiled in, words 1,2,3:
  - sumExpected=6 → handoff as normal.
  - sumExpected=7 → err=1, fetchSel stays 0, no resetPC pulse.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: state encoding, fetch-select
// values and default operand widths.
package boot_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_LEN_W  = 10;

    localparam logic FETCH_BIOS = 1'b0;
    localparam logic FETCH_MEM  = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_READ    = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_WRITE   = 3'd3;
    localparam state_t ST_HANDOFF = 3'd4;
    localparam state_t ST_RUN     = 3'd5;
    localparam state_t ST_ERROR   = 3'd6;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: copies a block of words from storage into instruction
// memory, then pulses the PC reset and switches fetch to instruction memory.
// Optional feature macro: BOOT_CHECKSUM_EN (running 32-bit sum of copied
// words checked against sumExpected before handoff; mismatch parks in ERROR).
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [LEN_W-1:0]  length,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [31:0]       rdData,
    input  logic              rdValid,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [31:0]       wrData,
    output logic              busy,
    output logic              fetchSel,
    output logic              resetPC,
`ifdef BOOT_CHECKSUM_EN
    input  logic [31:0]       sumExpected,
`endif
    output logic              err
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] src, src_n, dst, dst_n;
    logic [LEN_W-1:0]  rem, rem_n;
    logic [31:0]       data, data_n;
    logic              pulse_q;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       sum, sum_n, sum_exp, sum_exp_n;
    logic              err_q;
`endif

    // Next-state and operand datapath
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        rem_n   = rem;
        data_n  = data;
`ifdef BOOT_CHECKSUM_EN
        sum_n     = sum;
        sum_exp_n = sum_exp;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_n = (sumExpected == '0) ? ST_HANDOFF : ST_ERROR;
`else
                        state_n = ST_HANDOFF;
`endif
                    end else begin
                        src_n   = srcBase;
                        dst_n   = dstBase;
                        rem_n   = length;
                        state_n = ST_READ;
`ifdef BOOT_CHECKSUM_EN
                        sum_n     = '0;
                        sum_exp_n = sumExpected;
`endif
                    end
                end
            end
            ST_READ: state_n = ST_WAIT;
            ST_WAIT: begin
                if (rdValid) begin
                    data_n  = rdData;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                src_n = src + 1'b1;
                dst_n = dst + 1'b1;
                rem_n = rem - 1'b1;
`ifdef BOOT_CHECKSUM_EN
                sum_n = sum + data;
                if (rem == LEN_W'(1))
                    state_n = (sum_n == sum_exp) ? ST_HANDOFF : ST_ERROR;
                else
                    state_n = ST_READ;
`else
                state_n = (rem == LEN_W'(1)) ? ST_HANDOFF : ST_READ;
`endif
            end
            ST_HANDOFF: state_n = ST_RUN;
            default:    state_n = state;
        endcase
    end

    // State, operands and registered outputs derived from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            src      <= '0;
            dst      <= '0;
            rem      <= '0;
            data     <= '0;
            rdEn     <= 1'b0;
            rdAddr   <= '0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            busy     <= 1'b0;
            fetchSel <= FETCH_BIOS;
            pulse_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum      <= '0;
            sum_exp  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            src      <= src_n;
            dst      <= dst_n;
            rem      <= rem_n;
            data     <= data_n;
            rdEn     <= (state_n == ST_READ);
            rdAddr   <= src_n;
            wrEn     <= (state_n == ST_WRITE);
            wrAddr   <= dst_n;
            wrData   <= data_n;
            busy     <= (state_n inside {ST_READ, ST_WAIT, ST_WRITE, ST_HANDOFF});
            pulse_q  <= (state_n == ST_HANDOFF);
            if (state_n == ST_HANDOFF)
                fetchSel <= FETCH_MEM;
`ifdef BOOT_CHECKSUM_EN
            sum      <= sum_n;
            sum_exp  <= sum_exp_n;
            err_q    <= (state_n == ST_ERROR);
`endif
        end
    end

    // PC reset is the registered handoff pulse, also forced while reset is held
    assign resetPC = pulse_q | reset;

`ifdef BOOT_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: storage model with programmable
// read latency, scoreboard queues for expected reads and writes.
// Checksum cases run when BOOT_CHECKSUM_EN is defined.
module tb_boot_loader_ctrl;
    import boot_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  srcBase = '0, dstBase = '0, length = '0;
    logic [31:0] rdData = '0;
    logic        rdValid = 1'b0;
    logic        rdEn, wrEn, busy, fetchSel, resetPC, err;
    logic [9:0]  rdAddr, wrAddr;
    logic [31:0] wrData;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sumExpected = '0;
`endif

    always #5 clock = ~clock;

    boot_loader_ctrl #(.ADDR_W(10), .LEN_W(10)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .srcBase(srcBase), .dstBase(dstBase), .length(length),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy), .fetchSel(fetchSel), .resetPC(resetPC),
`ifdef BOOT_CHECKSUM_EN
        .sumExpected(sumExpected),
`endif
        .err(err)
    );

    logic [31:0] mem [0:1023];
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [9:0]  exp_rd_q [$];
    logic [41:0] exp_wr_q [$];
    logic [41:0] wr_e;
    logic [9:0]  paddr;
    int  lat = 1, cnt = 0, cyc = 0, t0 = 0;
    int  n_rd = 0, n_wr = 0, pulse_cnt = 0, pulse_cyc = -1, fs_cyc = -1;
    bit  pend = 0, valid_seen = 0;

    // Storage model: one response per rdEn after 'lat' cycles
    always @(posedge clock) begin
        cyc++;
        #1;
        rdValid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                rdValid = 1'b1;
                rdData  = mem[paddr];
                pend    = 0;
            end else cnt--;
        end
        if (rdEn) begin
            check("one_outstanding", 64'(pend), 0);
            if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", rdAddr, exp_rd_q.pop_front());
            pend  = 1;
            paddr = rdAddr;
            cnt   = lat;
            n_rd++;
        end
    end

    // Write scoreboard and handoff timing monitor
    always @(posedge clock) begin
        #2;
        if (wrEn) begin
            n_wr++;
            check("wr_after_valid", 64'(valid_seen), 1);
            valid_seen = 0;
            if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                wr_e = exp_wr_q.pop_front();
                check("wr_addr", wrAddr, wr_e[41:32]);
                check("wr_data", wrData, wr_e[31:0]);
            end
        end
        if (rdValid) valid_seen = 1;
        if (!reset && resetPC) begin
            pulse_cnt++;
            if (pulse_cyc < 0) pulse_cyc = cyc - t0;
        end
        if (fetchSel && fs_cyc < 0) fs_cyc = cyc - t0;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1 check("rst_resetPC_now", resetPC, 1);
        @(negedge clock);
        check("rst_fetchSel", fetchSel, FETCH_BIOS);
        check("rst_busy", busy, 0);
        check("rst_rdEn", rdEn, 0);
        check("rst_wrEn", wrEn, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_resetPC_after", resetPC, 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic go(input logic [9:0] s, input logic [9:0] d, input logic [9:0] l, input int latency);
        logic [9:0] a;
        lat = latency;
        n_rd = 0; n_wr = 0; pulse_cnt = 0; pulse_cyc = -1; fs_cyc = -1; valid_seen = 0;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 10'(i);
            exp_rd_q.push_back(a);
            exp_wr_q.push_back({d + 10'(i), mem[a]});
        end
        @(negedge clock);
        start = 1'b1; srcBase = s; dstBase = d; length = l;
        t0 = cyc;
        @(negedge clock);
        start = 1'b0;
        srcBase = 10'($urandom); dstBase = 10'($urandom); length = 10'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(fetchSel || err) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("done_in_budget", 64'(fetchSel | err), 1);
        repeat (3) @(negedge clock);
        check("queues_drained", 64'(exp_wr_q.size() + exp_rd_q.size()), 0);
    endtask

    initial begin
        logic [9:0] a;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        do_reset();

        // 4 words, 1-cycle latency
        go(10'h010, 10'h000, 10'd4, 1);
        wait_done(40);
        check("t1_n_wr", n_wr, 4);
        check("t1_pulse_cycle", 64'(pulse_cyc), 13);
        check("t1_fetch_cycle", 64'(fs_cyc), 13);
        check("t1_pulse_count", pulse_cnt, 1);
        check("t1_fetchSel_run", fetchSel, FETCH_MEM);
        check("t1_busy_run", busy, 0);

        // zero length: straight to handoff
        do_reset();
        go(10'h055, 10'h066, 10'd0, 1);
        wait_done(10);
        check("t2_n_rd", n_rd, 0);
        check("t2_n_wr", n_wr, 0);
        check("t2_pulse_cycle", 64'(pulse_cyc), 1);
        check("t2_fetch_cycle", 64'(fs_cyc), 1);

        // slow storage: 5-cycle latency
        do_reset();
        go(10'h120, 10'h0A0, 10'd2, 5);
        wait_done(60);
        check("t3_n_wr", n_wr, 2);
        check("t3_pulse_cycle", 64'(pulse_cyc), 15);

        // address wrap on both ports
        do_reset();
        go(10'h3FE, 10'h3FF, 10'd3, 1);
        wait_done(40);
        check("t4_n_rd", n_rd, 3);
        check("t4_pulse_cycle", 64'(pulse_cyc), 10);

        // reset during WAIT of second word, then restart
        do_reset();
        go(10'h100, 10'h200, 10'd3, 5);
        for (int k = 0; k < 50 && n_rd < 2; k++) @(negedge clock);
        check("t5_second_read", n_rd, 2);
        @(negedge clock);
        do_reset();
        repeat (10) @(negedge clock);
        check("t5_n_wr_aborted", n_wr, 1);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_fetchSel", fetchSel, FETCH_BIOS);
        go(10'h300, 10'h010, 10'd1, 1);
        wait_done(20);
        check("t5_restart_n_wr", n_wr, 1);
        check("t5_restart_pulse", 64'(pulse_cyc), 4);
        @(negedge clock);
        start = 1'b1; srcBase = 10'h001; dstBase = 10'h002; length = 10'd2;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("t5_run_no_read", n_rd, 1);
        check("t5_run_fetchSel", fetchSel, FETCH_MEM);
        check("t5_run_pulses", pulse_cnt, 1);
        check("t5_run_busy", busy, 0);

`ifdef BOOT_CHECKSUM_EN
        for (int i = 0; i < 3; i++) begin
            a = 10'h040 + 10'(i);
            mem[a] = 32'(i + 1);
        end
        do_reset();
        sumExpected = 32'd6;
        go(10'h040, 10'h080, 10'd3, 1);
        wait_done(40);
        check("cs_ok_err", err, 0);
        check("cs_ok_fetchSel", fetchSel, FETCH_MEM);
        check("cs_ok_pulses", pulse_cnt, 1);

        do_reset();
        sumExpected = 32'd7;
        go(10'h040, 10'h080, 10'd3, 1);
        wait_done(40);
        check("cs_bad_err", err, 1);
        check("cs_bad_fetchSel", fetchSel, FETCH_BIOS);
        check("cs_bad_pulses", pulse_cnt, 0);
        check("cs_bad_n_wr", n_wr, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
